// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg -- shared types and default constants for the clock-enable
// generator.
//   state_t           : control FSM states (IDLE, LOAD, SETTLE, LOCKED)
//   DEF_ACC_W         : default phase-accumulator width
//   DEF_SETTLE_CYCLES : default number of running cycles from load to locked
//   cnt_width()       : counter width needed to hold SETTLE_CYCLES-1
package clk_en_gen_pkg;

  localparam int DEF_ACC_W         = 32;
  localparam int DEF_SETTLE_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Width of a counter that must reach settle_cycles-1 (settle_cycles >= 2).
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if -- increment-load handshake for clk_en_gen.
//   inc       : per-channel phase increments, channel k at [k*ACC_W +: ACC_W]
//   inc_valid : requester has a new increment set
//   inc_ready : generator can accept a load this cycle
// Modports: master (requester side), slave (generator side).
interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic [NUM_CH*ACC_W-1:0] inc;
  logic                    inc_valid;
  logic                    inc_ready;

  modport master (output inc, output inc_valid, input inc_ready);
  modport slave  (input inc, input inc_valid, output inc_ready);

endinterface

// File: rtl/clk_en_nco.sv
// clk_en_nco -- one channel of the clock-enable generator: an increment
// register, a phase accumulator and a registered carry-out used as the enable.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_inc     : capture inc_in into the increment register
//   inc_in       : new phase increment
//   clear        : zero the accumulator and the enable (takes priority)
//   run          : advance the accumulator by one increment
//   ce           : one-cycle pulse after each accumulator wrap
module clk_en_nco
  import clk_en_gen_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_inc,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             clear,
  input  logic             run,
  output logic             ce
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic             ce_reg;
  logic [ACC_W:0]   sum;

  // One extra bit holds the carry; the wrap itself is the mod 2^ACC_W.
  assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};
  assign ce  = ce_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg <= '0;
      inc_reg <= '0;
      ce_reg  <= 1'b0;
    end else begin
      if (load_inc) begin
        inc_reg <= inc_in;
      end
      if (clear) begin
        acc_reg <= '0;
        ce_reg  <= 1'b0;
      end else if (run) begin
        acc_reg <= sum[ACC_W-1:0];
        ce_reg  <= sum[ACC_W];
      end else begin
        // Frozen or idle: phase holds, enable is suppressed.
        ce_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen -- multi-channel NCO clock-enable generator.
//   clk, reset_n : single clock, asynchronous active-low reset
//   cfg          : increment-load handshake (inc / inc_valid / inc_ready)
//   freeze       : hold accumulators and settle counter, suppress enables
//   ce           : per-channel one-cycle enable pulses
//   locked       : high once SETTLE_CYCLES running cycles elapsed since load
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  clk_en_gen_if.slave       cfg,
  input  logic              freeze,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             locked_reg;
  logic             accept;
  logic             running;
  logic             run;
  logic             clear;

  assign cfg.inc_ready = (state_reg != LOAD);
  assign accept        = cfg.inc_valid && cfg.inc_ready;
  assign running       = (state_reg == SETTLE) || (state_reg == LOCKED);
  // An accepted load outranks freeze; the accumulators are zeroed both on the
  // accept edge and on the edge leaving LOAD so ce stays low through LOAD.
  assign clear         = accept || (state_reg == LOAD);
  assign run           = running && !freeze && !accept;
  assign locked        = locked_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: begin
        if (accept) begin
          state_next = LOAD;
        end else if (!freeze) begin
          if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) state_next = LOCKED;
          else                                      cnt_next   = cnt_reg + 1'b1;
        end
      end
      LOCKED: begin
        if (accept) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      locked_reg <= (state_next == LOCKED);
    end
  end

  // All channels share load/clear/run so harmonic increments stay aligned.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_en_nco #(.ACC_W(ACC_W)) u_nco (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_inc (accept),
        .inc_in   (cfg.inc[gi*ACC_W +: ACC_W]),
        .clear    (clear),
        .run      (run),
        .ce       (ce[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen -- directed scoreboard bench for clk_en_gen
// (NUM_CH=3, ACC_W=8, SETTLE_CYCLES=16).
// Stimulus drives on falling edges and queues the expected {ce, locked,
// inc_ready} seen after the following rising edge; a monitor pops and
// compares each cycle. Expected enables follow from the NCO definition:
// after the j-th running step a channel pulses iff floor(j*inc/256) stepped.
module tb_clk_en_gen;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 8;
  localparam int SETTLE = 16;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        freeze  = 1'b0;
  logic [2:0]  ce;
  logic        locked;

  clk_en_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  clk_en_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cfg     (cfg_if),
    .freeze  (freeze),
    .ce      (ce),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  int          n_chk     = 0;
  int          n_fail    = 0;
  int          mon_cnt   = 0;
  logic [4:0]  exp_q[$];
  logic [23:0] cur_inc   = '0;
  int          j         = 0;
  bit          count_en  = 1'b0;
  int          pulse_cnt = 0;

  localparam logic [23:0] INC_B = {8'd0,   8'd64,  8'd128};
  localparam logic [23:0] INC_G = {8'd0,   8'd0,   8'd255};
  localparam logic [23:0] INC_X = {8'd255, 8'd128, 8'd64};
  localparam logic [23:0] INC_Y = {8'd255, 8'd1,   8'd85};
  localparam logic [23:0] INC_R = {8'd255, 8'd255, 8'd255};

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ce=%b locked=%b inc_ready=%b, want ce=%b locked=%b inc_ready=%b",
               name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: one comparison per queued expectation, just after the edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cnt++;
        chk($sformatf("cycle %0d", mon_cnt), {ce, locked, cfg_if.inc_ready}, e);
      end
    end
  end

  function automatic logic [2:0] carries(input logic [23:0] incs, input int jj);
    logic [2:0] c;
    for (int k = 0; k < 3; k++) begin
      int a;
      a    = int'(incs[k*8 +: 8]);
      c[k] = ((jj * a) >> 8) != (((jj - 1) * a) >> 8);
    end
    return c;
  endfunction

  task automatic drive(input logic v, input logic [23:0] d, input logic fz, input logic [4:0] e);
    @(negedge clk);
    if (count_en && ce[0]) pulse_cnt++;
    cfg_if.inc_valid = v;
    cfg_if.inc       = d;
    freeze           = fz;
    exp_q.push_back(e);
  endtask

  // Accept edge (LOAD: ready low) then LOAD exit edge (SETTLE, ce still 0).
  task automatic do_load(input logic [23:0] d, input logic fz);
    $display("load: inc ch2=%0d ch1=%0d ch0=%0d freeze=%0b", d[23:16], d[15:8], d[7:0], fz);
    drive(1'b1, d, fz, 5'b000_0_0);
    cur_inc = d;
    j       = 0;
    drive(1'b0, d, fz, 5'b000_0_1);
  endtask

  // One cycle in SETTLE/LOCKED; locked after SETTLE non-frozen steps.
  task automatic step(input logic fz);
    logic [2:0] c;
    if (!fz) j++;
    c = fz ? 3'b000 : carries(cur_inc, j);
    drive(1'b0, cur_inc, fz, {c, (j >= SETTLE), 1'b1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.inc_valid = 1'b0;
    cfg_if.inc       = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 5'b000_0_1);

    // Harmonic channels 128/64/0 into LOCKED.
    do_load(INC_B, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0);

    // Freeze 5 cycles in LOCKED, then resume.
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);

    // inc_valid held high: loads every other cycle.
    $display("load: inc_valid held high for 8 cycles");
    for (int i = 0; i < 8; i++)
      drive(1'b1, cur_inc, 1'b0, (i % 2 == 0) ? 5'b000_0_0 : 5'b000_0_1);
    j = 0;
    for (int i = 0; i < 20; i++) step(1'b0);

    // Freeze coinciding with an accepted load; counter holds while frozen.
    do_load(INC_G, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 22; i++) step(1'b0);

    // Reload in SETTLE at counter 10, then long run of inc 85.
    do_load(INC_X, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0);
    do_load(INC_Y, 1'b0);
    count_en = 1'b1;
    for (int i = 0; i < 768; i++) step(1'b0);
    count_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    n_chk++;
    if (pulse_cnt < 254 || pulse_cnt > 256) begin
      n_fail++;
      $display("FAIL ce0_pulse_count: got %0d pulses, want 255 +/- 1", pulse_cnt);
    end

    // Asynchronous reset mid-LOCKED with all channels pulsing.
    do_load(INC_R, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {ce, locked, cfg_if.inc_ready}, 5'b000_0_1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b0, INC_R, 1'b0, 5'b000_0_1);

    // A fresh load after reset works again.
    do_load(INC_B, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
